fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of the instruction memory port.
REQ-002 Parameter RESET_PC, default 0, byte address fetched first after reset.
REQ-003 Parameter HALT_PC, default 260 (0x104), byte address at which fetch stops.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_addr  output  ADDR_W  byte address to instruction memory, which decodes word index as imem_addr[ADDR_W-1:2].
REQ-007 imem_data  input  32  combinational instruction word for imem_addr.
REQ-008 stall  input  1  load-use hazard from ID; freeze PC and IF/ID.
REQ-009 jump  input  1  J decoded in ID this cycle.
REQ-010 jump_target  input  ADDR_W  byte target of jump, word-aligned.
REQ-011 branch_taken  input  1  resolved taken branch in EX this cycle.
REQ-012 branch_target  input  ADDR_W  byte target of branch, word-aligned.
REQ-013 ifid_instr  output  32  IF/ID instruction register.
REQ-014 ifid_pc4  output  ADDR_W  IF/ID register holding fetch PC + 4.
REQ-015 ifid_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-016 halted  output  1  fetch has reached HALT_PC and stopped.
REQ-017 flush_idex  output  1  combinational; kill the instruction currently in ID (branch redirect only).

Function
REQ-018 imem_addr SHALL equal the PC register; PC SHALL be word-aligned (bits [1:0] forced 0).
REQ-019 FSM states: RUN, REDIRECT, HALT.
REQ-020 Next-PC priority per cycle: branch_taken > jump > stall > halted > sequential PC+4.
REQ-021 PC+4 SHALL wrap modulo 2^ADDR_W (0x3FC -> 0x000) without error.
REQ-022 RUN, no event: PC <= PC+4; ifid_instr <= imem_data; ifid_pc4 <= PC+4; ifid_valid <= 1.
REQ-023 stall (no branch/jump): PC, ifid_instr, ifid_pc4, ifid_valid hold.
REQ-024 jump: PC <= jump_target; ifid_valid <= 0 (the wrong-path fetch is squashed); state -> REDIRECT.
REQ-025 branch_taken: PC <= branch_target; ifid_valid <= 0; flush_idex = 1 same cycle; state -> REDIRECT.
REQ-026 branch_taken with simultaneous stall or jump: branch wins; stall and jump ignored.
REQ-027 REDIRECT lasts exactly one cycle, fetches normally from the new PC, ifid_valid <= 1, returns to RUN; a further branch/jump in REDIRECT is honoured per REQ-020.
REQ-028 When PC == HALT_PC in RUN or REDIRECT with no branch/jump: state -> HALT; PC holds; ifid_valid <= 0; halted = 1.
REQ-029 HALT: PC frozen, ifid_valid stays 0; branch_taken still redirects and returns to REDIRECT (HALT exits only via branch or reset).
REQ-030 Branch/jump latency: target instruction appears in IF/ID with ifid_valid=1 on second edge after the event.
REQ-031 flush_idex SHALL be 0 in every cycle without branch_taken.

Reset
REQ-032 reset: PC=RESET_PC, state=RUN, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0.
REQ-033 reset SHALL override all inputs, including mid-stall or mid-REDIRECT; first fetch from RESET_PC on the cycle after reset deasserts.

Structure
REQ-034 Shared package holds: state enum (RUN/REDIRECT/HALT), ADDR_W default, NOP word 32'h0, instruction word width 32.
REQ-035 One sub-module natural: pc_next_mux (pure combinational priority select of REQ-020); FSM and IF/ID register stay in fetch_sequencer.

Verification
REQ-036 Reset, 4 free cycles -> imem_addr 0,4,8,C; ifid_pc4 4,8,C; ifid_valid 0 then 1.
REQ-037 PC=0xBC, stall 2 cycles -> imem_addr stays 0xBC, IF/ID unchanged, resumes 0xC0 after.
REQ-038 branch_taken, branch_target=0xE0 with stall=1 same cycle -> flush_idex=1, next imem_addr 0xE0, ifid_valid 0 then 1 with ifid_pc4=0xE4.
REQ-039 jump, jump_target=0x100 at PC=0xE8 -> next imem_addr 0x100, one bubble, ifid_pc4=0x104.
REQ-040 Sequential fetch to 0x104 -> halted=1, imem_addr held 0x104, ifid_valid=0 indefinitely; reset -> imem_addr 0.
REQ-041 RESET_PC=0x3F8 -> imem_addr 0x3F8, 0x3FC, 0x000 (wrap).

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int INSTR_W    = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    HALT
  } fetch_state_t;

  // Which rule won the next-PC priority this cycle; drives FSM and IF/ID update
  typedef enum logic [2:0] {
    SEL_BRANCH,
    SEL_JUMP,
    SEL_STALL,
    SEL_HALT,
    SEL_SEQ
  } pc_sel_t;

endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// rtl/fetch_sequencer_pc_next_mux.sv - priority select of the next fetch PC
module pc_next_mux
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_stall,
  input  logic              i_halt,
  output logic [ADDR_W-1:0] o_pc_next,
  output pc_sel_t           o_sel
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  always_comb begin
    o_sel     = SEL_SEQ;
    o_pc_next = i_pc + ADDR_W'(4);
    if (i_branch_taken) begin
      o_sel     = SEL_BRANCH;
      o_pc_next = i_branch_target & WORD_MASK;
    end else if (i_jump) begin
      o_sel     = SEL_JUMP;
      o_pc_next = i_jump_target & WORD_MASK;
    end else if (i_stall) begin
      o_sel     = SEL_STALL;
      o_pc_next = i_pc;
    end else if (i_halt) begin
      o_sel     = SEL_HALT;
      o_pc_next = i_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC register, fetch FSM and IF/ID pipeline register
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned HALT_PC  = 260
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               ifid_valid,
  output logic               halted,
  output logic               flush_idex
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC & ~32'd3);
  localparam logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(HALT_PC);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  pc_sel_t            w_sel;
  logic               w_jump_en;
  logic               w_halt;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [ADDR_W-1:0]  r_ifid_pc4;
  logic               r_ifid_valid;

  // Once halted, only a branch may restart fetch; a jump from ID is stale
  assign w_jump_en = jump && (r_state != HALT);
  assign w_halt    = (r_state == HALT) || (r_pc == HALT_ADDR);

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_mux (
    .i_pc            (r_pc),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (w_jump_en),
    .i_jump_target   (jump_target),
    .i_stall         (stall),
    .i_halt          (w_halt),
    .o_pc_next       (w_pc_next),
    .o_sel           (w_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_ADDR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (w_sel)
      SEL_BRANCH, SEL_JUMP: w_state_next = REDIRECT;
      SEL_HALT:             w_state_next = HALT;
      SEL_SEQ:              w_state_next = RUN;
      default:              w_state_next = r_state;
    endcase
  end

  // On a sequential fetch the mux output is exactly PC+4, reused for ifid_pc4
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (w_sel)
        SEL_BRANCH, SEL_JUMP, SEL_HALT: begin
          r_ifid_instr <= NOP_WORD;
          r_ifid_valid <= 1'b0;
        end
        SEL_SEQ: begin
          r_ifid_instr <= imem_data;
          r_ifid_pc4   <= w_pc_next;
          r_ifid_valid <= 1'b1;
        end
        default: begin
          r_ifid_valid <= r_ifid_valid;
        end
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;
  assign halted     = (r_state == HALT);
  assign flush_idex = branch_taken;

endmodule
